mdc_reorder_buf: RTL and testbench
==================================

# mdc_reorder_buf

Parametrised output reorder buffer for the radix-2 MDC FFT pipeline, replacing the fixed 32-point, 9-bit ping-pong stage. It accepts the two-lane, bit-reversed-order stream produced by the last MDC stage (one up/down pair per cycle) and emits a single natural-order stream at one sample per cycle, using two ping-pong banks. It adds the following behaviour:

- Selectable output order (natural or stream order).
- Frame sync with resync on a misplaced start marker.
- Overflow detection.
- Per-sample output index and frame markers.

## Interface
- WIDTH, 9: signed bits per real/imag component.
- LOG2N, 5: log2 of FFT size N. Legal range 2..10.
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  synchronous reset, active-high (asserted = 1).
- in_valid  in  1  up/down pair present this cycle.
- in_sof  in  1  qualifies in_valid; marks pair k=0 of a frame.
- in_up_re, in_up_im, in_dn_re, in_dn_im  in  WIDTH each  signed pair data.
- mode_bitrev  in  1  0: natural order out; 1: stream order out. Sampled at the start of each read-out frame.
- out_valid  out  1  sample present.
- out_sof, out_eof  out  1  first / last sample of an output frame.
- out_re, out_im  out  WIDTH  signed sample.
- out_idx  out  LOG2N  read position j, 0..N-1.
- ovf  out  1  one-cycle pulse: accepted-looking pair dropped because the write bank is busy.
- sof_err  out  1  one-cycle pulse: in_sof seen with write count ≠ 0.

## Operation
Storage layout:
- Two banks, each holding N complex words.
- Pair k (0..N/2-1): up is written to address bitrev(2k), dn to address bitrev(2k+1).
- bitrev is over LOG2N bits.
- Up addresses are always < N/2 and dn addresses are always ≥ N/2. Each bank is therefore two half-size single-write-port memories.

Bank states are EMPTY, FULL, READING.

Writer:
- Sync: after reset, waits for in_valid & in_sof. Pairs arriving before sync are discarded silently.
- Write: an accepted pair is written to wr_bank at count wcnt, then wcnt increments. Pairs with in_valid low are ignored; gaps are allowed.
- Frame end: when wcnt reaches N/2-1 and that pair is written, wr_bank is marked FULL, wr_bank toggles, and wcnt is cleared.
- Overflow: if in_valid is high while wr_bank is not EMPTY, the pair is dropped, ovf pulses, and wcnt holds.
- Resync: in_sof with wcnt ≠ 0 pulses sof_err. wcnt restarts at 0 and the pair is written as k=0 of a new frame. Earlier partial data is overwritten and never emitted.

Reader:
- Start: when idle and a FULL bank exists (oldest first), it latches mode_bitrev and marks the bank READING.
- Read: emits j = 0..N-1, one per cycle, with no gaps. Read address = j when mode_bitrev=0, bitrev(j) when mode_bitrev=1.
- Resulting order: natural order X[0..N-1], or the original stream order (up0, dn0, up1, dn1, …).
- Frame end: after j = N-1 the bank becomes EMPTY. If the other bank is FULL, its read starts on the very next cycle with no bubble.
- Output flags: out_sof with j=0, out_eof with j=N-1, out_idx=j.

Simultaneous events:
- The writer can fill one bank while the other is READING.
- A bank becoming EMPTY at the same edge as a write attempt to it: the write is accepted. Free-by-edge takes priority over overflow.

Arithmetic: data passes unmodified, with no scaling or rounding.

## Timing
- Reset values: out_valid, out_sof, out_eof, ovf, sof_err = 0; out_re, out_im, out_idx = 0; both banks EMPTY; wcnt = 0; writer unsynced; reader idle.
- Reset mid-operation discards all frames. The cycle after reset asserts, every output equals its reset value.
- Latency: last pair of a frame sampled at edge E, with the reader idle, gives j=0 on the outputs after edge E+2. Timing is 1 cycle for the state update plus 1 cycle for synchronous memory read and output register.
- Output frame length is exactly N consecutive cycles.
- Sustained throughput: one frame per N cycles at N/2 pairs per frame. Gapless input (N/2 pairs every N/2 cycles) overflows.
- ovf and sof_err are asserted the cycle after the offending input edge.

## Test plan
- N=32, W=9, mode 0. One frame: pair k has up_re=bitrev(2k), dn_re=bitrev(2k+1), im=-up_re. Required:
  - out_re = 0..31 in order, out_im = -out_re, out_idx = out_re.
  - out_sof at idx 0, out_eof at idx 31.
  - First out_valid 2 cycles after the last pair.
- Same frame with mode_bitrev=1 → out_re = 0,16,8,24,4,20,… (bitrev(j)).
- Three frames of 16 pairs, one every 32 cycles, with random in_valid gaps inside the 32-cycle windows → 96 contiguous-per-frame outputs, no ovf. Frames 2→3 have no bubble when back-to-back.
- Gapless input of 48 pairs: frames 0 and 1 accepted. Frame 2 pairs arriving while bank 0 is READING are dropped, ovf pulses once per dropped pair, and no corrupted output appears.
- in_sof at wcnt=7, then 16 pairs → one sof_err pulse, and only the restarted frame is emitted, correct.
- rst_n=1 during read-out at j=10 → next cycle all outputs 0. Pairs without in_sof are ignored; the next in_sof frame is emitted normally.

Source files
------------

// File: rtl/mdc_reorder_buf.sv
// mdc_reorder_buf
//   Output reorder buffer for the radix-2 MDC FFT pipeline. Accepts the
//   two-lane bit-reversed stream (one up/down pair per cycle) and emits one
//   complex sample per cycle in natural order (mode_bitrev=0) or in the
//   original stream order (mode_bitrev=1), using two ping-pong banks.
//
//   Ports
//     clk, rst_n          clock; synchronous reset, active-high (asserted = 1)
//     in_valid, in_sof    pair present; pair k=0 of a frame
//     in_up_*, in_dn_*    signed up/down pair data
//     mode_bitrev         output order, latched at the start of each read-out
//     out_valid/sof/eof   sample present; first/last sample of a frame
//     out_re, out_im      signed sample
//     out_idx             read position j
//     ovf                 pulse: pair dropped because the write bank is busy
//     sof_err             pulse: in_sof seen with a partially written frame
module mdc_reorder_buf #(
    parameter int WIDTH = 9,
    parameter int LOG2N = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic                    in_sof,
    input  logic signed [WIDTH-1:0] in_up_re,
    input  logic signed [WIDTH-1:0] in_up_im,
    input  logic signed [WIDTH-1:0] in_dn_re,
    input  logic signed [WIDTH-1:0] in_dn_im,
    input  logic                    mode_bitrev,
    output logic                    out_valid,
    output logic                    out_sof,
    output logic                    out_eof,
    output logic signed [WIDTH-1:0] out_re,
    output logic signed [WIDTH-1:0] out_im,
    output logic [LOG2N-1:0]        out_idx,
    output logic                    ovf,
    output logic                    sof_err
);

    localparam int HB   = LOG2N - 1;   // address bits of one half-bank
    localparam int HALF = 1 << HB;

    typedef enum logic [1:0] {B_EMPTY, B_FULL, B_READING} bank_st_e;

    function automatic logic [LOG2N-1:0] bitrev_n(input logic [LOG2N-1:0] v);
        logic [LOG2N-1:0] r;
        for (int unsigned i = 0; i < LOG2N; i++) r[i] = v[LOG2N-1-i];
        return r;
    endfunction

    function automatic logic [HB-1:0] bitrev_h(input logic [HB-1:0] v);
        logic [HB-1:0] r;
        for (int unsigned i = 0; i < HB; i++) r[i] = v[HB-1-i];
        return r;
    endfunction

    // Up words (addresses < N/2) and down words (addresses >= N/2) live in
    // separate half-size memories; pair k lands at bitrev(k) in both halves.
    logic [2*WIDTH-1:0] mem_lo [2][HALF];
    logic [2*WIDTH-1:0] mem_hi [2][HALF];

    bank_st_e         bank_st_q [2];
    bank_st_e         bank_st_d [2];
    logic             synced_q, synced_d;
    logic             wr_bank_q, wr_bank_d;
    logic [HB-1:0]    wcnt_q, wcnt_d;
    logic             rd_active_q, rd_active_d;
    logic             rd_bank_q, rd_bank_d;
    logic             rd_mode_q, rd_mode_d;
    logic [LOG2N-1:0] rd_j_q, rd_j_d;

    logic                    out_valid_q, out_valid_d;
    logic                    out_sof_q, out_sof_d;
    logic                    out_eof_q, out_eof_d;
    logic signed [WIDTH-1:0] out_re_q, out_re_d;
    logic signed [WIDTH-1:0] out_im_q, out_im_d;
    logic [LOG2N-1:0]        out_idx_q, out_idx_d;
    logic                    ovf_q, ovf_d;
    logic                    sof_err_q, sof_err_d;

    logic             rd_other;
    logic             rd_last;
    logic             wr_free;
    logic             wr_en;
    logic [HB-1:0]    wr_k;
    logic [HB-1:0]    wr_idx;
    logic [LOG2N-1:0] rd_addr;
    logic [2*WIDTH-1:0] rd_word;

    assign rd_other = ~rd_bank_q;
    assign wr_idx   = bitrev_h(wr_k);

    // Bank bookkeeping, reader sequencing and writer control
    always_comb begin
        bank_st_d   = bank_st_q;
        rd_active_d = rd_active_q;
        rd_bank_d   = rd_bank_q;
        rd_mode_d   = rd_mode_q;
        rd_j_d      = rd_j_q;
        synced_d    = synced_q;
        wr_bank_d   = wr_bank_q;
        wcnt_d      = wcnt_q;
        wr_en       = 1'b0;
        ovf_d       = 1'b0;
        sof_err_d   = in_valid && in_sof && (wcnt_q != '0);
        wr_k        = in_sof ? '0 : wcnt_q;
        rd_last     = rd_active_q && (&rd_j_q);

        // Banks fill alternately, so the reader simply alternates too.
        if (rd_active_q) begin
            rd_j_d = rd_j_q + 1'b1;
            if (rd_last) begin
                bank_st_d[rd_bank_q] = B_EMPTY;
                rd_bank_d            = rd_other;
                rd_j_d               = '0;
                if (bank_st_q[rd_other] == B_FULL) begin
                    bank_st_d[rd_other] = B_READING;
                    rd_mode_d           = mode_bitrev;
                end else begin
                    rd_active_d = 1'b0;
                end
            end
        end else if (bank_st_q[rd_bank_q] == B_FULL) begin
            bank_st_d[rd_bank_q] = B_READING;
            rd_active_d          = 1'b1;
            rd_mode_d            = mode_bitrev;
            rd_j_d               = '0;
        end

        // A bank being released on this edge already counts as free.
        wr_free = (bank_st_q[wr_bank_q] == B_EMPTY) ||
                  (rd_last && (rd_bank_q == wr_bank_q));

        if (in_valid && (synced_q || in_sof)) begin
            if (!wr_free) begin
                ovf_d = 1'b1;
            end else begin
                wr_en    = 1'b1;
                synced_d = 1'b1;
                if (&wr_k) begin
                    bank_st_d[wr_bank_q] = B_FULL;
                    wr_bank_d            = ~wr_bank_q;
                    wcnt_d               = '0;
                end else begin
                    wcnt_d = wr_k + 1'b1;
                end
            end
        end
    end

    // Read path: memory read and output register share one edge
    always_comb begin
        rd_addr     = rd_mode_q ? bitrev_n(rd_j_q) : rd_j_q;
        rd_word     = rd_addr[HB] ? mem_hi[rd_bank_q][rd_addr[HB-1:0]]
                                  : mem_lo[rd_bank_q][rd_addr[HB-1:0]];
        out_valid_d = rd_active_q;
        out_sof_d   = rd_active_q && (rd_j_q == '0);
        out_eof_d   = rd_last;
        out_idx_d   = rd_active_q ? rd_j_q : '0;
        out_re_d    = rd_active_q ? rd_word[2*WIDTH-1:WIDTH] : '0;
        out_im_d    = rd_active_q ? rd_word[WIDTH-1:0] : '0;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_lo[wr_bank_q][wr_idx] <= {in_up_re, in_up_im};
            mem_hi[wr_bank_q][wr_idx] <= {in_dn_re, in_dn_im};
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            bank_st_q[0] <= B_EMPTY;
            bank_st_q[1] <= B_EMPTY;
            synced_q     <= 1'b0;
            wr_bank_q    <= 1'b0;
            wcnt_q       <= '0;
            rd_active_q  <= 1'b0;
            rd_bank_q    <= 1'b0;
            rd_mode_q    <= 1'b0;
            rd_j_q       <= '0;
            out_valid_q  <= 1'b0;
            out_sof_q    <= 1'b0;
            out_eof_q    <= 1'b0;
            out_re_q     <= '0;
            out_im_q     <= '0;
            out_idx_q    <= '0;
            ovf_q        <= 1'b0;
            sof_err_q    <= 1'b0;
        end else begin
            bank_st_q    <= bank_st_d;
            synced_q     <= synced_d;
            wr_bank_q    <= wr_bank_d;
            wcnt_q       <= wcnt_d;
            rd_active_q  <= rd_active_d;
            rd_bank_q    <= rd_bank_d;
            rd_mode_q    <= rd_mode_d;
            rd_j_q       <= rd_j_d;
            out_valid_q  <= out_valid_d;
            out_sof_q    <= out_sof_d;
            out_eof_q    <= out_eof_d;
            out_re_q     <= out_re_d;
            out_im_q     <= out_im_d;
            out_idx_q    <= out_idx_d;
            ovf_q        <= ovf_d;
            sof_err_q    <= sof_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sof   = out_sof_q;
    assign out_eof   = out_eof_q;
    assign out_re    = out_re_q;
    assign out_im    = out_im_q;
    assign out_idx   = out_idx_q;
    assign ovf       = ovf_q;
    assign sof_err   = sof_err_q;

endmodule

// File: tb/tb_mdc_reorder_buf.sv
// Testbench for mdc_reorder_buf (N=32, WIDTH=9): directed frames whose
// stored word at address a carries value a (+32 per frame tag), so natural
// read-out yields j and stream-order read-out yields bitrev(j).
module tb_mdc_reorder_buf;

    localparam int WIDTH = 9;
    localparam int LOG2N = 5;
    localparam int N     = 32;
    localparam int HALF  = 16;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b1;
    logic                    in_valid = 1'b0;
    logic                    in_sof = 1'b0;
    logic signed [WIDTH-1:0] in_up_re = '0, in_up_im = '0;
    logic signed [WIDTH-1:0] in_dn_re = '0, in_dn_im = '0;
    logic                    mode_bitrev = 1'b0;
    logic                    out_valid, out_sof, out_eof, ovf, sof_err;
    logic signed [WIDTH-1:0] out_re, out_im;
    logic [LOG2N-1:0]        out_idx;

    mdc_reorder_buf #(.WIDTH(WIDTH), .LOG2N(LOG2N)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof),
        .in_up_re(in_up_re), .in_up_im(in_up_im),
        .in_dn_re(in_dn_re), .in_dn_im(in_dn_im),
        .mode_bitrev(mode_bitrev),
        .out_valid(out_valid), .out_sof(out_sof), .out_eof(out_eof),
        .out_re(out_re), .out_im(out_im), .out_idx(out_idx),
        .ovf(ovf), .sof_err(sof_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_edge = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic signed [WIDTH-1:0] re;
        logic signed [WIDTH-1:0] im;
        logic [LOG2N-1:0]        idx;
        logic                    sof;
        logic                    eof;
        int                      cyc;
    } samp_t;

    samp_t cap[$];
    int ovf_cnt = 0, serr_cnt = 0, first_ovf_cyc = -1, first_serr_cyc = -1;

    // Recorder only: captures output samples and pulse counts
    always @(negedge clk) begin
        samp_t s;
        if (out_valid === 1'b1) begin
            s.re = out_re; s.im = out_im; s.idx = out_idx;
            s.sof = out_sof; s.eof = out_eof; s.cyc = cyc;
            cap.push_back(s);
        end
        if (ovf === 1'b1) begin
            if (ovf_cnt == 0) first_ovf_cyc = cyc;
            ovf_cnt++;
        end
        if (sof_err === 1'b1) begin
            if (serr_cnt == 0) first_serr_cyc = cyc;
            serr_cnt++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic int brev(input int v);
        int r = 0;
        for (int i = 0; i < LOG2N; i++) if (v[i]) r |= 1 << (LOG2N - 1 - i);
        return r;
    endfunction

    task automatic clear_mon();
        cap.delete();
        ovf_cnt = 0; serr_cnt = 0; first_ovf_cyc = -1; first_serr_cyc = -1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0; in_sof = 1'b0;
        end
    endtask

    task automatic send_pair(input int f, input int k, input bit sof);
        int u, d;
        u = brev(2 * k) + 32 * f;
        d = brev(2 * k + 1) + 32 * f;
        @(negedge clk);
        in_valid = 1'b1; in_sof = sof;
        in_up_re = WIDTH'(u); in_up_im = WIDTH'(-u);
        in_dn_re = WIDTH'(d); in_dn_im = WIDTH'(-d);
        last_edge = cyc + 1;
    endtask

    task automatic send_frame(input int f);
        for (int k = 0; k < HALF; k++) send_pair(f, k, k == 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0; in_sof = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        clear_mon();
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({out_valid, out_sof, out_eof, ovf, sof_err, out_re, out_im, out_idx} !== '0)
            begin errors++; $display("FAIL reset_outputs: got v=%b s=%b e=%b ovf=%b serr=%b re=%0d im=%0d idx=%0d, want all 0",
                out_valid, out_sof, out_eof, ovf, sof_err, out_re, out_im, out_idx); end
        rst_n = 1'b0;
        clear_mon();
        idle(10);
        checks++;
        if (cap.size() != 0) begin errors++; $display("FAIL reset_idle: got %0d samples, want 0", cap.size()); end
    endtask

    task automatic test_natural();
        logic signed [WIDTH-1:0] er, ei;
        do_reset();
        mode_bitrev = 1'b0;
        send_frame(0);
        idle(45);
        checks++;
        if (cap.size() != N) begin errors++; $display("FAIL nat_count: got %0d want %0d", cap.size(), N); end
        checks++;
        if (cap.size() > 0 && cap[0].cyc != last_edge + 2)
            begin errors++; $display("FAIL nat_latency: got cyc %0d want %0d", cap[0].cyc, last_edge + 2); end
        for (int j = 0; j < cap.size(); j++) begin
            er = WIDTH'(j); ei = WIDTH'(-j);
            checks++;
            if (cap[j].re !== er || cap[j].im !== ei || cap[j].idx !== LOG2N'(j) ||
                cap[j].sof !== (j == 0) || cap[j].eof !== (j == N - 1) || cap[j].cyc != cap[0].cyc + j)
                begin errors++; $display("FAIL nat[%0d]: got re=%0d im=%0d idx=%0d sof=%b eof=%b cyc=%0d, want re=%0d im=%0d idx=%0d sof=%b eof=%b cyc=%0d",
                    j, cap[j].re, cap[j].im, cap[j].idx, cap[j].sof, cap[j].eof, cap[j].cyc,
                    er, ei, j, j == 0, j == N - 1, cap[0].cyc + j); end
        end
    endtask

    task automatic test_bitrev();
        logic signed [WIDTH-1:0] er, ei;
        do_reset();
        mode_bitrev = 1'b1;
        send_frame(1);
        idle(45);
        mode_bitrev = 1'b0;
        checks++;
        if (cap.size() != N) begin errors++; $display("FAIL rev_count: got %0d want %0d", cap.size(), N); end
        for (int j = 0; j < cap.size(); j++) begin
            er = WIDTH'(brev(j) + 32); ei = WIDTH'(-(brev(j) + 32));
            checks++;
            if (cap[j].re !== er || cap[j].im !== ei || cap[j].idx !== LOG2N'(j) ||
                cap[j].sof !== (j == 0) || cap[j].eof !== (j == N - 1))
                begin errors++; $display("FAIL rev[%0d]: got re=%0d im=%0d idx=%0d sof=%b eof=%b, want re=%0d im=%0d idx=%0d",
                    j, cap[j].re, cap[j].im, cap[j].idx, cap[j].sof, cap[j].eof, er, ei, j); end
        end
    endtask

    task automatic test_gaps();
        int last_e[3];
        int k, s0;
        logic signed [WIDTH-1:0] er, ei;
        do_reset();
        for (int f = 0; f < 3; f++) begin
            k = 0;
            for (int slot = 0; slot < 2 * HALF; slot++) begin
                if (k < HALF && $urandom_range(0, 31 - slot) < 32'(HALF - k)) begin
                    send_pair(f, k, k == 0);
                    k++;
                end else begin
                    idle(1);
                end
            end
            last_e[f] = last_edge;
        end
        idle(80);
        checks++;
        if (cap.size() != 3 * N) begin errors++; $display("FAIL gap_count: got %0d want %0d", cap.size(), 3 * N); end
        checks++;
        if (ovf_cnt != 0) begin errors++; $display("FAIL gap_ovf: got %0d ovf pulses want 0", ovf_cnt); end
        if (cap.size() >= 3 * N) begin
            for (int f = 0; f < 3; f++) begin
                s0 = (f == 0) ? last_e[0] + 2
                   : ((cap[N * f - 1].cyc + 1 > last_e[f] + 2) ? cap[N * f - 1].cyc + 1 : last_e[f] + 2);
                checks++;
                if (cap[N * f].cyc != s0)
                    begin errors++; $display("FAIL gap_start[%0d]: got cyc %0d want %0d", f, cap[N * f].cyc, s0); end
            end
        end
        for (int i = 0; i < cap.size(); i++) begin
            er = WIDTH'((i % N) + 32 * (i / N)); ei = WIDTH'(-((i % N) + 32 * (i / N)));
            checks++;
            if (cap[i].re !== er || cap[i].im !== ei || cap[i].idx !== LOG2N'(i % N) ||
                cap[i].sof !== (i % N == 0) || cap[i].eof !== (i % N == N - 1) ||
                cap[i].cyc != cap[i - (i % N)].cyc + (i % N))
                begin errors++; $display("FAIL gap[%0d]: got re=%0d im=%0d idx=%0d sof=%b eof=%b cyc=%0d, want re=%0d im=%0d idx=%0d",
                    i, cap[i].re, cap[i].im, cap[i].idx, cap[i].sof, cap[i].eof, cap[i].cyc, er, ei, i % N); end
        end
    endtask

    task automatic test_overflow();
        int e0, f2_first;
        logic signed [WIDTH-1:0] er, ei;
        do_reset();
        send_frame(0);
        e0 = last_edge;
        send_frame(1);
        f2_first = last_edge + 1;
        send_frame(2);
        idle(60);
        checks++;
        if (ovf_cnt != HALF) begin errors++; $display("FAIL ovf_count: got %0d want %0d", ovf_cnt, HALF); end
        checks++;
        if (first_ovf_cyc != f2_first) begin errors++; $display("FAIL ovf_timing: got cyc %0d want %0d", first_ovf_cyc, f2_first); end
        checks++;
        if (serr_cnt != 0) begin errors++; $display("FAIL ovf_serr: got %0d want 0", serr_cnt); end
        checks++;
        if (cap.size() != 2 * N) begin errors++; $display("FAIL ovf_out_count: got %0d want %0d", cap.size(), 2 * N); end
        checks++;
        if (cap.size() > 0 && cap[0].cyc != e0 + 2)
            begin errors++; $display("FAIL ovf_latency: got cyc %0d want %0d", cap[0].cyc, e0 + 2); end
        for (int i = 0; i < cap.size(); i++) begin
            er = WIDTH'((i % N) + 32 * (i / N)); ei = WIDTH'(-((i % N) + 32 * (i / N)));
            checks++;
            if (cap[i].re !== er || cap[i].im !== ei || cap[i].idx !== LOG2N'(i % N) || cap[i].cyc != cap[0].cyc + i)
                begin errors++; $display("FAIL ovf_out[%0d]: got re=%0d im=%0d idx=%0d cyc=%0d, want re=%0d im=%0d idx=%0d cyc=%0d",
                    i, cap[i].re, cap[i].im, cap[i].idx, cap[i].cyc, er, ei, i % N, cap[0].cyc + i); end
        end
    endtask

    task automatic test_resync();
        int es;
        logic signed [WIDTH-1:0] er, ei;
        do_reset();
        for (int k = 0; k < 7; k++) send_pair(3, k, k == 0);
        es = last_edge + 1;
        send_frame(1);
        idle(45);
        checks++;
        if (serr_cnt != 1) begin errors++; $display("FAIL resync_count: got %0d want 1", serr_cnt); end
        checks++;
        if (first_serr_cyc != es) begin errors++; $display("FAIL resync_timing: got cyc %0d want %0d", first_serr_cyc, es); end
        checks++;
        if (ovf_cnt != 0) begin errors++; $display("FAIL resync_ovf: got %0d want 0", ovf_cnt); end
        checks++;
        if (cap.size() != N) begin errors++; $display("FAIL resync_out_count: got %0d want %0d", cap.size(), N); end
        for (int j = 0; j < cap.size(); j++) begin
            er = WIDTH'(j + 32); ei = WIDTH'(-(j + 32));
            checks++;
            if (cap[j].re !== er || cap[j].im !== ei || cap[j].idx !== LOG2N'(j))
                begin errors++; $display("FAIL resync[%0d]: got re=%0d im=%0d idx=%0d, want re=%0d im=%0d idx=%0d",
                    j, cap[j].re, cap[j].im, cap[j].idx, er, ei, j); end
        end
    endtask

    task automatic test_reset_midread();
        bit found = 1'b0;
        logic signed [WIDTH-1:0] er, ei;
        do_reset();
        send_frame(2);
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            in_valid = 1'b0; in_sof = 1'b0;
            if (out_valid === 1'b1 && out_idx === 5'd10) found = 1'b1;
        end
        checks++;
        if (!found) begin errors++; $display("FAIL midrst_reach_j10: got no j=10 within 60 cycles, want j=10"); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({out_valid, out_sof, out_eof, ovf, sof_err, out_re, out_im, out_idx} !== '0)
            begin errors++; $display("FAIL midrst_outputs: got v=%b re=%0d im=%0d idx=%0d, want all 0",
                out_valid, out_re, out_im, out_idx); end
        rst_n = 1'b0;
        clear_mon();
        for (int k = 1; k < 6; k++) send_pair(0, k, 1'b0);
        idle(40);
        checks++;
        if (cap.size() != 0 || ovf_cnt != 0 || serr_cnt != 0)
            begin errors++; $display("FAIL midrst_unsynced: got samples=%0d ovf=%0d serr=%0d, want 0 0 0",
                cap.size(), ovf_cnt, serr_cnt); end
        send_frame(3);
        idle(45);
        checks++;
        if (cap.size() != N) begin errors++; $display("FAIL midrst_count: got %0d want %0d", cap.size(), N); end
        checks++;
        if (cap.size() > 0 && cap[0].cyc != last_edge + 2)
            begin errors++; $display("FAIL midrst_latency: got cyc %0d want %0d", cap[0].cyc, last_edge + 2); end
        for (int j = 0; j < cap.size(); j++) begin
            er = WIDTH'(j + 96); ei = WIDTH'(-(j + 96));
            checks++;
            if (cap[j].re !== er || cap[j].im !== ei || cap[j].idx !== LOG2N'(j))
                begin errors++; $display("FAIL midrst[%0d]: got re=%0d im=%0d idx=%0d, want re=%0d im=%0d idx=%0d",
                    j, cap[j].re, cap[j].im, cap[j].idx, er, ei, j); end
        end
    endtask

    initial begin
        test_reset();
        test_natural();
        test_bitrev();
        test_gaps();
        test_overflow();
        test_resync();
        test_reset_midread();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
